// File: rtl/if_stage.sv
// Instruction fetch stage: an issue register drives the SRAM address, and a response register
// presents the returned word to decode. Stalls, branches and exception redirects are handled here.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        flush_i,
  input  logic [31:0] excp_pc_i,
  output logic        inst_sram_en,
  output logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_rdata,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_adel_o
);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_adel_q, resp_adel_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_inst_q, hold_inst_d;

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

  // Next-state selection; priority is flush, then stall, then branch, then sequential.
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    resp_pc_d    = resp_pc_q;
    resp_valid_d = resp_valid_q;
    resp_adel_d  = resp_adel_q;
    hold_valid_d = hold_valid_q;
    hold_inst_d  = hold_inst_q;
    if (flush_i) begin
      fetch_pc_d   = excp_pc_i;
      resp_valid_d = 1'b0;
      resp_adel_d  = 1'b0;
      hold_valid_d = 1'b0;
    end else if (stall_i) begin
      // The SRAM keeps re-reading fetch_pc, so the word for resp_pc must be captured once.
      if (!hold_valid_q) begin
        hold_inst_d  = inst_sram_rdata;
        hold_valid_d = 1'b1;
      end else begin
        hold_inst_d  = hold_inst_q;
        hold_valid_d = 1'b1;
      end
    end else if (br_taken_i) begin
      fetch_pc_d   = br_target_i;
      resp_pc_d    = fetch_pc_q;
      resp_valid_d = 1'b0;
      resp_adel_d  = 1'b0;
      hold_valid_d = 1'b0;
    end else begin
      fetch_pc_d   = fetch_pc_q + 32'd4;
      resp_pc_d    = fetch_pc_q;
      resp_valid_d = 1'b1;
      resp_adel_d  = pc_misaligned(fetch_pc_q);
      hold_valid_d = 1'b0;
    end
  end

  // Pipeline state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q   <= RESET_PC;
      resp_pc_q    <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_adel_q  <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_inst_q  <= 32'd0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      resp_pc_q    <= resp_pc_d;
      resp_valid_q <= resp_valid_d;
      resp_adel_q  <= resp_adel_d;
      hold_valid_q <= hold_valid_d;
      hold_inst_q  <= hold_inst_d;
    end
  end

  // Output mapping; a misaligned fetch never reads the SRAM and presents a zero word.
  always_comb begin
    inst_sram_addr = fetch_pc_q;
    inst_sram_en   = (!rst) && (!pc_misaligned(fetch_pc_q));
    if_pc_o        = resp_pc_q;
    if_valid_o     = resp_valid_q;
    if_adel_o      = resp_adel_q;
    if (resp_adel_q) begin
      if_inst_o = 32'd0;
    end else if (hold_valid_q) begin
      if_inst_o = hold_inst_q;
    end else begin
      if_inst_o = inst_sram_rdata;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a one-cycle-latency SRAM model returns address-derived words,
// and expected PCs and words are written out by hand.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        br_taken_i = 1'b0;
  logic [31:0] br_target_i = 32'd0;
  logic        flush_i = 1'b0;
  logic [31:0] excp_pc_i = 32'd0;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_adel_o;
  logic        garbage = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  if_stage dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .br_taken_i(br_taken_i),
    .br_target_i(br_target_i), .flush_i(flush_i), .excp_pc_i(excp_pc_i),
    .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr),
    .inst_sram_rdata(inst_sram_rdata), .if_valid_o(if_valid_o), .if_pc_o(if_pc_o),
    .if_inst_o(if_inst_o), .if_adel_o(if_adel_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h0f0f0f0f;
  endfunction

  // SRAM model: one-cycle read latency, optional garbage injection.
  always_ff @(posedge clk) begin
    if (garbage) inst_sram_rdata <= 32'hdeadbeef;
    else if (inst_sram_en) inst_sram_rdata <= word_of(inst_sram_addr);
    else inst_sram_rdata <= inst_sram_rdata;
  end

  initial inst_sram_rdata = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] inst, input logic adel);
    check({tag, "_valid"}, {31'd0, if_valid_o}, {31'd0, v});
    check({tag, "_pc"}, if_pc_o, pc);
    check({tag, "_inst"}, if_inst_o, inst);
    check({tag, "_adel"}, {31'd0, if_adel_o}, {31'd0, adel});
  endtask

  initial begin
    step();
    check("rst_valid", {31'd0, if_valid_o}, 32'd0);
    check("rst_pc", if_pc_o, 32'd0);
    check("rst_en", {31'd0, inst_sram_en}, 32'd0);
    check("rst_addr", inst_sram_addr, 32'hbfc00000);
    rst = 1'b0;
    #1;
    check("rel_en", {31'd0, inst_sram_en}, 32'd1);

    // Sequential fetch from reset vector
    step(); check_out("seq0", 1'b1, 32'hbfc00000, word_of(32'hbfc00000), 1'b0);
    step(); check_out("seq1", 1'b1, 32'hbfc00004, word_of(32'hbfc00004), 1'b0);

    // Three-cycle stall with garbage SRAM data
    stall_i = 1'b1; garbage = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); check_out("stall", 1'b1, 32'hbfc00004, word_of(32'hbfc00004), 1'b0);
      check("stall_addr", inst_sram_addr, 32'hbfc00008);
    end
    stall_i = 1'b0; garbage = 1'b0;
    step(); check_out("post_stall", 1'b1, 32'hbfc00008, word_of(32'hbfc00008), 1'b0);
    check("post_stall_addr", inst_sram_addr, 32'hbfc0000c);
    step(); check("seq_c", if_pc_o, 32'hbfc0000c);
    step(); check("seq_10", if_pc_o, 32'hbfc00010);
    step(); check_out("dslot", 1'b1, 32'hbfc00014, word_of(32'hbfc00014), 1'b0);

    // Taken branch: delay slot accepted, one bubble, then target
    br_taken_i = 1'b1; br_target_i = 32'hbfc00100;
    step(); check("br_bubble", {31'd0, if_valid_o}, 32'd0);
    check("br_addr", inst_sram_addr, 32'hbfc00100);
    br_taken_i = 1'b0;
    step(); check_out("br_tgt", 1'b1, 32'hbfc00100, word_of(32'hbfc00100), 1'b0);

    // Flush beats stall and branch
    flush_i = 1'b1; stall_i = 1'b1; br_taken_i = 1'b1; br_target_i = 32'hbfc00200;
    excp_pc_i = 32'hbfc00380;
    step(); check("fl_valid", {31'd0, if_valid_o}, 32'd0);
    check("fl_addr", inst_sram_addr, 32'hbfc00380);
    check("fl_adel", {31'd0, if_adel_o}, 32'd0);
    flush_i = 1'b0; stall_i = 1'b0; br_taken_i = 1'b0;
    step(); check_out("fl_pc", 1'b1, 32'hbfc00380, word_of(32'hbfc00380), 1'b0);

    // Misaligned branch target
    br_taken_i = 1'b1; br_target_i = 32'h80000002;
    step(); check("mis_en", {31'd0, inst_sram_en}, 32'd0);
    check("mis_bubble", {31'd0, if_valid_o}, 32'd0);
    br_taken_i = 1'b0;
    step(); check_out("mis", 1'b1, 32'h80000002, 32'd0, 1'b1);
    check("mis_next_addr", inst_sram_addr, 32'h80000006);
    step(); check_out("mis2", 1'b1, 32'h80000006, 32'd0, 1'b1);

    // Address wrap past 2^32
    flush_i = 1'b1; excp_pc_i = 32'hfffffffc;
    step(); flush_i = 1'b0;
    step(); check_out("wrap", 1'b1, 32'hfffffffc, word_of(32'hfffffffc), 1'b0);
    check("wrap_addr", inst_sram_addr, 32'h00000000);
    step(); check("wrap_pc", if_pc_o, 32'h00000000);

    // Reset in the middle of a stall
    stall_i = 1'b1; garbage = 1'b1;
    step();
    rst = 1'b1;
    #1;
    check_out("mid_rst", 1'b0, 32'd0, 32'hdeadbeef, 1'b0);
    check("mid_rst_en", {31'd0, inst_sram_en}, 32'd0);
    check("mid_rst_addr", inst_sram_addr, 32'hbfc00000);
    step();
    rst = 1'b0; stall_i = 1'b0; garbage = 1'b0;
    step(); check_out("restart", 1'b1, 32'hbfc00000, word_of(32'hbfc00000), 1'b0);
    step(); check("restart_pc1", if_pc_o, 32'hbfc00004);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
